maxi_read_bridge: RTL and testbench
===================================

# maxi_read_bridge

Converts the packed read-master stream ports of the accelerator top level into a standard AXI3 64-bit read master toward the SoC memory port. Read requests arrive as 33-bit packed address tokens and are issued as fixed-length INCR bursts. Returned beats are buffered in a credit-managed FIFO and delivered as 65-bit packed data tokens. The block sits directly downstream of the accelerator's MAXI0 read-address output and directly upstream of its MAXI0 read-data input.

## Interface
Parameters:
- BURST_BEATS, 16: beats per burst; ARLEN = BURST_BEATS-1; range 1..16.
- FIFO_DEPTH, 64: read-data FIFO entries; power of two, integer multiple of BURST_BEATS.
- MAX_OUTSTANDING, 4: maximum bursts in flight, 1..15.

Ports:
- IP_CLK  in  1  sole clock; all logic on the rising edge.
- IP_ARESET_N  in  1  reset, asynchronous, active-low.
- ip_araddr  in  33  packed request; [32] valid, [31:0] byte address.
- ip_araddr_ready  out  1  request accepted when high with [32] high.
- ip_rdata  out  65  packed beat; [64] valid, [63:0] data.
- ip_rdata_ready  in  1  consumer ready.
- m_araddr  out  32  AXI AR address.
- m_arvalid  out  1  AXI AR valid.
- m_arready  in  1  AXI AR ready.
- m_arlen  out  4  constant BURST_BEATS-1.
- m_arsize  out  2  constant 2'b11 (8 bytes).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_rdata  in  64  AXI R data.
- m_rvalid  in  1  AXI R valid.
- m_rready  out  1  AXI R ready.
- m_rresp  in  2  AXI R response.
- m_rlast  in  1  AXI R last.
- err_resp  out  1  sticky: some beat had m_rresp != 2'b00.
- err_last  out  1  sticky: m_rlast disagreed with the beat count.
- outstanding  out  4  bursts accepted but last beat not yet received.

## Operation
- AR slot: one register (addr, full flag). ip_araddr_ready = !full && credit >= BURST_BEATS && outstanding < MAX_OUTSTANDING. Accept loads the slot, deducts BURST_BEATS from credit, increments outstanding.
- m_arvalid = full; m_araddr = slot address, passed unchanged. Slot clears on m_arvalid && m_arready. Once m_arvalid is high, it and m_araddr hold until the handshake.
- Credit: counter 0..FIFO_DEPTH, reset to FIFO_DEPTH. +1 per ip_rdata pop, -BURST_BEATS per request accept. Same-cycle events apply the net change. Credit guarantees FIFO space for every beat of every issued burst.
- R path: m_rready = !fifo_full. Each m_rvalid && m_rready pushes m_rdata. A beat counter 0..BURST_BEATS-1 wraps on the last beat.
  - If m_rlast != (count == BURST_BEATS-1), err_last is set; the counter still follows the count, not m_rlast.
  - If m_rresp != 0, err_resp is set; data is forwarded unchanged.
  - outstanding decrements on the counted last beat.
- Output: ip_rdata[64] = !fifo_empty; [63:0] = FIFO head. Pop on ip_rdata[64] && ip_rdata_ready.
- FIFO: circular pointers with wrap bit; full and empty derive from the pointers.

## Timing
- Reset: m_arvalid=0, m_araddr=0, m_rready=0 during reset (1 after release), ip_araddr_ready=0 during reset, ip_rdata=0, err_*=0, outstanding=0, credit=FIFO_DEPTH, beat count 0. m_arlen, m_arsize, m_arburst are constant.
- Request accepted in cycle N gives m_arvalid high in cycle N+1. At most one request every 2 cycles.
- Beat pushed in cycle N is visible on ip_rdata in cycle N+1. There is no same-cycle bypass into an empty FIFO.
- Full FIFO: m_rready is low even if a pop occurs the same cycle. It rises the cycle after the pop.
- Simultaneous accept and last beat: outstanding is unchanged.
- Asynchronous reset mid-burst discards all FIFO contents, the slot and counters immediately. Sticky errors clear only on reset.

## Test plan
- Single request 0x1000_0000, memory returns 16 beats 0..15 with m_rlast on beat 15 -> m_arvalid the cycle after accept with m_arlen=15, m_arsize=3, m_arburst=1; ip_rdata delivers 0..15 in order; outstanding goes 1 then 0; errors stay 0.
- 5 back-to-back requests, m_arready held low -> exactly 1 accepted until the AR handshake. With m_arready=1 and no R beats returned, the 5th request is refused because outstanding=4 and credit=0 (FIFO_DEPTH=64).
- ip_rdata_ready=0, 4 bursts returned -> FIFO holds 64 beats, m_rready=0, no further accepts; one pop -> m_rready=1 the next cycle, ip_araddr_ready stays 0 until 16 pops.
- m_rlast asserted on beat 7 of 16 -> err_last=1, the burst still counts 16 beats; m_rresp=2'b10 on one beat -> err_resp=1 and the data is still delivered.
- Accept and last beat of the previous burst in the same cycle -> outstanding unchanged; credit nets correctly.
- Reset asserted mid-burst with the FIFO half full -> all outputs return to their reset values asynchronously; after release, a fresh request behaves as in the first scenario.

Source files
------------

// File: rtl/maxi_read_bridge.sv
// Packed read-request / read-data stream to AXI3 64-bit read master bridge.
// Fixed-length INCR bursts; returned beats buffered in a credit-managed FIFO.
module maxi_read_bridge #(
    parameter int BURST_BEATS     = 16,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        IP_CLK,
    input  logic        IP_ARESET_N,
    input  logic [32:0] ip_araddr,
    output logic        ip_araddr_ready,
    output logic [64:0] ip_rdata,
    input  logic        ip_rdata_ready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [3:0]  m_arlen,
    output logic [1:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic [63:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    output logic        err_resp,
    output logic        err_last,
    output logic [3:0]  outstanding
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    localparam logic [CRW-1:0] CREDIT_MAX   = CRW'(FIFO_DEPTH);
    localparam logic [CRW-1:0] CREDIT_BURST = CRW'(BURST_BEATS);
    localparam logic [CRW-1:0] CREDIT_ONE   = CRW'(1);
    localparam logic [CW-1:0]  LAST_BEAT    = CW'(BURST_BEATS - 1);
    localparam logic [CW-1:0]  BEAT_ONE     = CW'(1);
    localparam logic [3:0]     OUT_MAX      = 4'(MAX_OUTSTANDING);
    localparam logic [AW:0]    PTR_ONE      = (AW+1)'(1);

    logic            live_q;
    logic            slotFull_q;
    logic [31:0]     slotAddr_q;
    logic [CRW-1:0]  credit_q, credit_d;
    logic [3:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]   beatCnt_q, beatCnt_d;
    logic [AW:0]     wptr_q, rptr_q;
    logic            errResp_q, errLast_q;
    logic [63:0]     mem [FIFO_DEPTH];

    logic fifoEmpty, fifoFull;
    logic accept, arHandshake, push, pop, countedLast;

    assign fifoEmpty = (wptr_q == rptr_q);
    assign fifoFull  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // live_q keeps both ready outputs low while reset is held
    assign ip_araddr_ready = live_q && !slotFull_q && (credit_q >= CREDIT_BURST)
                             && (outstanding_q < OUT_MAX);
    assign m_rready        = live_q && !fifoFull;

    assign accept      = ip_araddr[32] && ip_araddr_ready;
    assign arHandshake = slotFull_q && m_arready;
    assign push        = m_rvalid && m_rready;
    assign pop         = !fifoEmpty && ip_rdata_ready;
    assign countedLast = push && (beatCnt_q == LAST_BEAT);

    assign m_arvalid   = slotFull_q;
    assign m_araddr    = slotAddr_q;
    assign m_arlen     = 4'(BURST_BEATS - 1);
    assign m_arsize    = 2'b11;
    assign m_arburst   = 2'b01;
    assign ip_rdata    = {!fifoEmpty, fifoEmpty ? 64'd0 : mem[rptr_q[AW-1:0]]};
    assign err_resp    = errResp_q;
    assign err_last    = errLast_q;
    assign outstanding = outstanding_q;

    always_comb begin
        credit_d = credit_q;
        if (pop)
            credit_d = credit_d + CREDIT_ONE;
        if (accept)
            credit_d = credit_d - CREDIT_BURST;

        outstanding_d = outstanding_q;
        case ({accept, countedLast})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // The beat counter alone defines burst boundaries; m_rlast is only checked
        beatCnt_d = beatCnt_q;
        if (push)
            beatCnt_d = (beatCnt_q == LAST_BEAT) ? '0 : beatCnt_q + BEAT_ONE;
    end

    always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
        if (!IP_ARESET_N) begin
            live_q        <= 1'b0;
            slotFull_q    <= 1'b0;
            slotAddr_q    <= '0;
            credit_q      <= CREDIT_MAX;
            outstanding_q <= '0;
            beatCnt_q     <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            errResp_q     <= 1'b0;
            errLast_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                slotFull_q <= 1'b1;
                slotAddr_q <= ip_araddr[31:0];
            end else if (arHandshake) begin
                slotFull_q <= 1'b0;
            end
            credit_q      <= credit_d;
            outstanding_q <= outstanding_d;
            beatCnt_q     <= beatCnt_d;
            if (push)
                wptr_q <= wptr_q + PTR_ONE;
            if (pop)
                rptr_q <= rptr_q + PTR_ONE;
            if (push && (m_rresp != 2'b00))
                errResp_q <= 1'b1;
            if (push && (m_rlast != (beatCnt_q == LAST_BEAT)))
                errLast_q <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge IP_CLK) begin
        if (push)
            mem[wptr_q[AW-1:0]] <= m_rdata;
    end

endmodule

// File: tb/tb_maxi_read_bridge.sv
// Scoreboard bench for maxi_read_bridge: AR addresses and R data are queued
// when driven and compared when the DUT hands them on.
module tb_maxi_read_bridge;

    localparam int BEATS = 16;
    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [32:0] ip_araddr;
    logic        ip_araddr_ready;
    logic [64:0] ip_rdata;
    logic        ip_rdata_ready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_arlen;
    logic [1:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [63:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        err_resp;
    logic        err_last;
    logic [3:0]  outstanding;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] rExp[$];
    logic [31:0] arExp[$];

    maxi_read_bridge #(.BURST_BEATS(BEATS), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(4)) dut (
        .IP_CLK          (clk),
        .IP_ARESET_N     (rst_n),
        .ip_araddr       (ip_araddr),
        .ip_araddr_ready (ip_araddr_ready),
        .ip_rdata        (ip_rdata),
        .ip_rdata_ready  (ip_rdata_ready),
        .m_araddr        (m_araddr),
        .m_arvalid       (m_arvalid),
        .m_arready       (m_arready),
        .m_arlen         (m_arlen),
        .m_arsize        (m_arsize),
        .m_arburst       (m_arburst),
        .m_rdata         (m_rdata),
        .m_rvalid        (m_rvalid),
        .m_rready        (m_rready),
        .m_rresp         (m_rresp),
        .m_rlast         (m_rlast),
        .err_resp        (err_resp),
        .err_last        (err_last),
        .outstanding     (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Monitors sample on the falling edge, when inputs and state are settled
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_arvalid && m_arready) begin
                if (arExp.size() == 0)
                    checkOutput("ar_unexpected", 64'(m_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
                else
                    checkOutput("araddr", 64'(m_araddr), 64'(arExp.pop_front()));
            end
            if (ip_araddr[32] && ip_araddr_ready)
                arExp.push_back(ip_araddr[31:0]);
            if (ip_rdata[64] && ip_rdata_ready) begin
                if (rExp.size() == 0)
                    checkOutput("rdata_unexpected", ip_rdata[63:0], 64'hDEAD_DEAD_DEAD_DEAD);
                else
                    checkOutput("rdata", ip_rdata[63:0], rExp.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int n, input logic [31:0] base, input int maxCycles, output int got);
        got = 0;
        for (int c = 0; c < maxCycles && got < n; c++) begin
            @(posedge clk); #1;
            ip_araddr = {1'b1, base + 32'(got) * 32'h80};
            @(negedge clk);
            if (ip_araddr_ready)
                got++;
        end
        @(posedge clk); #1;
        ip_araddr = '0;
    endtask

    task automatic sendBeat(input logic [63:0] data, input logic last, input logic [1:0] resp, input bit chkBypass);
        int n = 0;
        @(posedge clk); #1;
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rlast  = last;
        m_rresp  = resp;
        @(negedge clk);
        while (!m_rready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_rready) begin
            checkOutput("rbeat_timeout", 64'd0, 64'd1);
        end else begin
            rExp.push_back(data);
            if (chkBypass)
                checkOutput("no_bypass", 64'(ip_rdata[64]), 64'd0);
        end
    endtask

    task automatic sendBurst(input logic [63:0] base, input int lastIdx, input int respIdx, input bit chkBypass);
        for (int i = 0; i < BEATS; i++)
            sendBeat(base + 64'(i), (i == lastIdx), (i == respIdx) ? 2'b10 : 2'b00, chkBypass && (i == 0));
    endtask

    task automatic idleR();
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (rExp.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(rExp.size()), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_empty"}, 64'(ip_rdata[64]), 64'd0);
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_arvalid"}, 64'(m_arvalid), 64'd0);
        checkOutput({pfx, "_araddr"}, 64'(m_araddr), 64'd0);
        checkOutput({pfx, "_rready"}, 64'(m_rready), 64'd0);
        checkOutput({pfx, "_ip_arready"}, 64'(ip_araddr_ready), 64'd0);
        checkOutput({pfx, "_rdata_valid"}, 64'(ip_rdata[64]), 64'd0);
        checkOutput({pfx, "_rdata"}, ip_rdata[63:0], 64'd0);
        checkOutput({pfx, "_err_resp"}, 64'(err_resp), 64'd0);
        checkOutput({pfx, "_err_last"}, 64'(err_last), 64'd0);
        checkOutput({pfx, "_outstanding"}, 64'(outstanding), 64'd0);
        checkOutput({pfx, "_credit"}, 64'(dut.credit_q), 64'(DEPTH));
        checkOutput({pfx, "_arlen"}, 64'(m_arlen), 64'd15);
        checkOutput({pfx, "_arsize"}, 64'(m_arsize), 64'd3);
        checkOutput({pfx, "_arburst"}, 64'(m_arburst), 64'd1);
    endtask

    task automatic runBasic(input string pfx);
        int got;
        @(posedge clk); #1;
        m_arready      = 1'b1;
        ip_rdata_ready = 1'b1;
        applyStimulus(1, 32'h1000_0000, 10, got);
        checkOutput({pfx, "_accept"}, 64'(got), 64'd1);
        @(negedge clk);
        checkOutput({pfx, "_arvalid"}, 64'(m_arvalid), 64'd1);
        checkOutput({pfx, "_araddr"}, 64'(m_araddr), 64'h1000_0000);
        checkOutput({pfx, "_out1"}, 64'(outstanding), 64'd1);
        sendBurst(64'd0, 15, -1, 1'b1);
        idleR();
        waitDrain({pfx, "_drain"});
        checkOutput({pfx, "_out0"}, 64'(outstanding), 64'd0);
        checkOutput({pfx, "_err_resp"}, 64'(err_resp), 64'd0);
        checkOutput({pfx, "_err_last"}, 64'(err_last), 64'd0);
    endtask

    initial begin
        int got;
        rst_n          = 1'b0;
        ip_araddr      = '0;
        ip_rdata_ready = 1'b0;
        m_arready      = 1'b0;
        m_rdata        = '0;
        m_rvalid       = 1'b0;
        m_rresp        = 2'b00;
        m_rlast        = 1'b0;

        repeat (3) @(negedge clk);
        checkResetState("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("live_rready", 64'(m_rready), 64'd1);
        checkOutput("live_arready", 64'(ip_araddr_ready), 64'd1);

        runBasic("basic");

        // AR stall: only one request fits until the handshake, then the 4-burst limit
        @(posedge clk); #1;
        m_arready      = 1'b0;
        ip_rdata_ready = 1'b0;
        applyStimulus(5, 32'h2000_0000, 10, got);
        checkOutput("stall_accepts", 64'(got), 64'd1);
        checkOutput("stall_arvalid", 64'(m_arvalid), 64'd1);
        checkOutput("stall_araddr", 64'(m_araddr), 64'h2000_0000);
        @(posedge clk); #1;
        m_arready = 1'b1;
        applyStimulus(4, 32'h2000_1000, 30, got);
        checkOutput("limit_accepts", 64'(got), 64'd3);
        @(negedge clk);
        checkOutput("limit_out", 64'(outstanding), 64'd4);
        checkOutput("limit_arready", 64'(ip_araddr_ready), 64'd0);
        checkOutput("limit_credit", 64'(dut.credit_q), 64'd0);

        // Consumer stalled: four bursts fill the FIFO completely
        for (int b = 0; b < 4; b++)
            sendBurst(64'h3000_0000_0000_0000 + 64'(b) * 64'h100, 15, -1, 1'b0);
        idleR();
        @(negedge clk);
        checkOutput("full_rready", 64'(m_rready), 64'd0);
        checkOutput("full_out", 64'(outstanding), 64'd0);
        checkOutput("full_arready", 64'(ip_araddr_ready), 64'd0);
        checkOutput("full_valid", 64'(ip_rdata[64]), 64'd1);
        @(posedge clk); #1;
        ip_rdata_ready = 1'b1;
        @(negedge clk);
        checkOutput("pop_cycle_rready", 64'(m_rready), 64'd0);
        @(posedge clk); #1;
        ip_rdata_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_pop_rready", 64'(m_rready), 64'd1);
        checkOutput("after_pop_arready", 64'(ip_araddr_ready), 64'd0);
        @(posedge clk); #1;
        ip_rdata_ready = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        ip_rdata_ready = 1'b0;
        @(negedge clk);
        checkOutput("pop15_arready", 64'(ip_araddr_ready), 64'd0);
        @(posedge clk); #1;
        ip_rdata_ready = 1'b1;
        @(posedge clk); #1;
        ip_rdata_ready = 1'b0;
        @(negedge clk);
        checkOutput("pop16_arready", 64'(ip_araddr_ready), 64'd1);
        ip_rdata_ready = 1'b1;
        waitDrain("full_drain");

        // Early m_rlast and a SLVERR beat; the burst must still span 16 beats
        applyStimulus(2, 32'h4000_0000, 10, got);
        checkOutput("err_accepts", 64'(got), 64'd2);
        sendBurst(64'h4000_0000_0000_0000, 7, 3, 1'b0);
        idleR();
        @(negedge clk);
        checkOutput("err_out_mid", 64'(outstanding), 64'd1);
        checkOutput("err_last_set", 64'(err_last), 64'd1);
        checkOutput("err_resp_set", 64'(err_resp), 64'd1);
        sendBurst(64'h4100_0000_0000_0000, 15, -1, 1'b0);
        idleR();
        waitDrain("err_drain");
        checkOutput("err_out_end", 64'(outstanding), 64'd0);

        // Accept and counted last beat on the same edge
        applyStimulus(1, 32'h5000_0000, 10, got);
        for (int i = 0; i < BEATS - 1; i++)
            sendBeat(64'h5000_0000_0000_0000 + 64'(i), 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        ip_araddr = {1'b1, 32'h5000_0800};
        m_rvalid  = 1'b1;
        m_rdata   = 64'h5000_0000_0000_000F;
        m_rlast   = 1'b1;
        m_rresp   = 2'b00;
        @(negedge clk);
        checkOutput("same_arready", 64'(ip_araddr_ready), 64'd1);
        checkOutput("same_rready", 64'(m_rready), 64'd1);
        checkOutput("same_out_before", 64'(outstanding), 64'd1);
        if (m_rready)
            rExp.push_back(64'h5000_0000_0000_000F);
        @(posedge clk); #1;
        ip_araddr = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        @(negedge clk);
        checkOutput("same_out_after", 64'(outstanding), 64'd1);
        sendBurst(64'h5100_0000_0000_0000, 15, -1, 1'b0);
        idleR();
        waitDrain("same_drain");
        checkOutput("same_out_end", 64'(outstanding), 64'd0);
        checkOutput("same_credit", 64'(dut.credit_q), 64'(DEPTH));
        checkOutput("err_sticky", 64'({err_last, err_resp}), 64'd3);

        // Asynchronous reset mid-burst with the FIFO partly filled
        ip_rdata_ready = 1'b0;
        applyStimulus(3, 32'h6000_0000, 12, got);
        checkOutput("mid_accepts", 64'(got), 64'd3);
        sendBurst(64'h6000_0000_0000_0000, 15, -1, 1'b0);
        sendBurst(64'h6100_0000_0000_0000, 15, -1, 1'b0);
        for (int i = 0; i < 5; i++)
            sendBeat(64'h6200_0000_0000_0000 + 64'(i), 1'b0, 2'b00, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        rExp.delete();
        arExp.delete();
        m_rvalid = 1'b0;
        #1;
        checkResetState("async_rst");
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        runBasic("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
